// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: latches an N x N operand pair on start and streams it into
// the west and north edges of an N x N systolic array with the diagonal skew
// the array needs, preceded by an accumulator-clear cycle and followed by a
// zero flush, ending with a one-cycle done pulse.
//
// Handshake: start is a level-sampled request accepted only on a clock edge
// where the block is idle (busy=0) and reset is not asserted; any start seen
// while busy (including the DONE cycle) is dropped, never queued. done is a
// single-cycle completion strobe with no back-pressure.
//
// Reset: rst_n is synchronous and active-HIGH despite its name.

module sa_skew_feeder #(
    parameter int N     = 4,
    parameter int WDATA = 4,
    parameter int DRAIN = N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N*N*WDATA-1:0]   mat_a,
    input  logic [N*N*WDATA-1:0]   mat_b,
    output logic [N*WDATA-1:0]     matrix_W,
    output logic [N*WDATA-1:0]     matrix_N,
    output logic                   sa_clr,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             dbg_state
);

    // Last FEED index; the counter is shared between FEED and FLUSH.
    localparam int FEED_LAST = 2 * N - 2;
    localparam int CMAX      = (2 * N > DRAIN + 1) ? 2 * N : DRAIN + 1;
    localparam int CW        = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   capture;
    logic [N*N*WDATA-1:0]   a_q;
    logic [N*N*WDATA-1:0]   b_q;
    logic [N*WDATA-1:0]     w_d;
    logic [N*WDATA-1:0]     n_d;

    assign dbg_state = state_q;

    // Next-state, wavefront counter and the operand vectors for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        w_d     = '0;
        n_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    capture = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == CW'(FEED_LAST)) begin
                    cnt_d   = '0;
                    state_d = (DRAIN == 0) ? S_DONE : S_FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == CW'(DRAIN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Row i sees A[i][k] and column j sees B[k][j] on wavefront t = i+k
        // (zero-based), so lane i lags lane 0 by i cycles.
        if (state_d == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(cnt_d) == i + k) begin
                        w_d[i*WDATA +: WDATA] = a_q[(i*N+k)*WDATA +: WDATA];
                        n_d[i*WDATA +: WDATA] = b_q[(k*N+i)*WDATA +: WDATA];
                    end
                end
            end
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            matrix_W <= '0;
            matrix_N <= '0;
            sa_clr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            matrix_W <= w_d;
            matrix_N <= n_d;
            sa_clr   <= (state_d == S_CLEAR);
            busy     <= (state_d != S_IDLE);
            done     <= (state_d == S_DONE);
        end
    end

    // Operand snapshot taken on acceptance; later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (capture && !rst_n) begin
            a_q <= mat_a;
            b_q <= mat_b;
        end
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: a spec-level job model pushes the expected
// per-cycle output frames on acceptance; a negedge monitor pops and compares.
// A behavioural systolic array is driven by the DUT outputs and its result is
// compared with A*B at every done pulse.

module tb_sa_skew_feeder;

    localparam int N       = 4;
    localparam int WDATA   = 4;
    localparam int DRAIN   = 4;
    localparam int JOB_LEN = 1 + (2 * N - 1) + DRAIN + 1;
    localparam int VW      = N * WDATA;
    localparam int MW      = N * N * WDATA;
    localparam int FW      = 3 + 2 * VW;
    localparam int PW      = N * N * 16;

    // clock / reset / stimulus signals
    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [MW-1:0]  mat_a = '0;
    logic [MW-1:0]  mat_b = '0;
    logic [VW-1:0]  matrix_W;
    logic [VW-1:0]  matrix_N;
    logic           sa_clr;
    logic           busy;
    logic           done;
    logic [2:0]     dbg_state;

    logic [FW-1:0]  exp_q[$];
    logic [PW-1:0]  prod_q[$];
    int             chk_cnt = 0;
    int             pass_cnt = 0;
    int             model_remain = 0;

    int             acc[N][N];
    int             a_r[N][N];
    int             b_r[N][N];

    always #5 clk = ~clk;

    sa_skew_feeder #(.N(N), .WDATA(WDATA), .DRAIN(DRAIN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .matrix_W (matrix_W),
        .matrix_N (matrix_N),
        .sa_clr   (sa_clr),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    function automatic int elem(input logic [MW-1:0] m, input int r, input int c);
        return int'(m[(r*N+c)*WDATA +: WDATA]);
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int e = 0; e < N * N; e++) m[e*WDATA +: WDATA] = WDATA'($urandom_range(1, 15));
        return m;
    endfunction

    task automatic check(input string name, input logic ok,
                         input logic [PW-1:0] got, input logic [PW-1:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Job model: accept when idle, then push the whole expected job as frames.
    always @(posedge clk) begin : job_model
        logic [VW-1:0] w;
        logic [VW-1:0] n;
        logic [PW-1:0] p;
        int t;
        int s;
        if (rst_n) begin
            model_remain = 0;
            exp_q.delete();
            prod_q.delete();
        end else if (model_remain > 0) begin
            model_remain--;
        end else if (start) begin
            model_remain = JOB_LEN;
            for (int c = 1; c <= JOB_LEN; c++) begin
                w = '0;
                n = '0;
                if (c >= 2 && c <= 2 * N) begin
                    t = c - 2;
                    for (int r = 0; r < N; r++) begin
                        if (t - r >= 0 && t - r < N) begin
                            w[r*WDATA +: WDATA] = WDATA'(elem(mat_a, r, t - r));
                            n[r*WDATA +: WDATA] = WDATA'(elem(mat_b, t - r, r));
                        end
                    end
                end
                exp_q.push_back({1'b1, (c == 1), (c == JOB_LEN), w, n});
            end
            p = '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    s = 0;
                    for (int k = 0; k < N; k++) s += elem(mat_a, i, k) * elem(mat_b, k, j);
                    p[(i*N+j)*16 +: 16] = 16'(s);
                end
            end
            prod_q.push_back(p);
        end
    end

    // Behavioural output-stationary array fed by the DUT edge operands.
    always @(posedge clk) begin : array_model
        int na[N][N];
        int nb[N][N];
        int ain;
        int bin;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain = int'(matrix_W[i*WDATA +: WDATA]);
                else        ain = a_r[i][j-1];
                if (i == 0) bin = int'(matrix_N[j*WDATA +: WDATA]);
                else        bin = b_r[i-1][j];
                na[i][j] = ain;
                nb[i][j] = bin;
                if (sa_clr) acc[i][j] = 0;
                else        acc[i][j] = acc[i][j] + ain * bin;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_r[i][j] = sa_clr ? 0 : na[i][j];
                b_r[i][j] = sa_clr ? 0 : nb[i][j];
            end
        end
    end

    // Monitor: every cycle pop the expected frame (idle frame when none).
    always @(negedge clk) begin : monitor
        logic [FW-1:0] got;
        logic [FW-1:0] exp;
        logic [PW-1:0] gp;
        logic [PW-1:0] ep;
        got = {busy, sa_clr, done, matrix_W, matrix_N};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("frame", got == exp, PW'(got), PW'(exp));
        if (done && prod_q.size() > 0) begin
            ep = prod_q.pop_front();
            gp = '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    gp[(i*N+j)*16 +: 16] = 16'(acc[i][j]);
            check("array_product", gp == ep, gp, ep);
        end
    end

    // Stimulus sequence.
    initial begin
        repeat (3) step();
        rst_n = 1'b0;
        step();

        // Ramp A, all-ones B, single-cycle start.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                mat_a[(i*N+k)*WDATA +: WDATA] = WDATA'(4 * i + k + 1);
                mat_b[(i*N+k)*WDATA +: WDATA] = WDATA'(1);
            end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();

        // start held high for 20 cycles: one job, re-accepted right after DONE.
        mat_a = rand_mat();
        mat_b = rand_mat();
        start = 1'b1;
        repeat (20) step();
        start = 1'b0;
        repeat (16) step();

        // Inputs changed one cycle after acceptance must not reach the outputs.
        mat_a = rand_mat();
        mat_b = rand_mat();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        mat_a = '1;
        mat_b = rand_mat();
        repeat (16) step();

        // Reset during FEED t=2 with a coincident start, then a full job.
        mat_a = rand_mat();
        mat_b = rand_mat();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        rst_n = 1'b0;
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();

        // Randomized traffic with occasional resets.
        repeat (400) begin
            mat_a = rand_mat();
            mat_b = rand_mat();
            start = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 99) == 0);
            step();
        end
        rst_n = 1'b0;
        start = 1'b0;
        repeat (20) step();

        check("drain", exp_q.size() == 0, PW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sa_skew_feeder.md
SA_SKEW_FEEDER -- requirements
Module: sa_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension (N x N).
REQ-002 SHALL have parameter WDATA, default 4: operand element width in bits.
REQ-003 SHALL have parameter DRAIN, default N: zero-flush cycles after the last skewed wavefront.
REQ-004 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1: synchronous, active-high reset (asserted at 1, sampled on clk).
REQ-006 SHALL have port start  input  1: request one multiplication; accepted only in IDLE.
REQ-007 SHALL have port mat_a  input  N*N*WDATA: matrix A, element A[i][k] at bit offset ((i-1)*N+(k-1))*WDATA, i,k in 1..N.
REQ-008 SHALL have port mat_b  input  N*N*WDATA: matrix B, same packing as mat_a.
REQ-009 SHALL have port matrix_W  output  N x WDATA: west-edge row operands to the array.
REQ-010 SHALL have port matrix_N  output  N x WDATA: north-edge column operands to the array.
REQ-011 SHALL have port sa_clr  output  1: one-cycle accumulator clear for the array.
REQ-012 SHALL have port busy  output  1: high while a job is in progress.
REQ-013 SHALL have port done  output  1: one-cycle pulse when the array result is complete.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, FEED, FLUSH, DONE; all outputs registered.
REQ-015 In IDLE with start=1, SHALL capture mat_a/mat_b into internal registers and move to CLEAR; later changes to mat_a/mat_b SHALL NOT affect the job.
REQ-016 CLEAR SHALL last exactly 1 cycle with sa_clr=1 and matrix_W/matrix_N all zero, then enter FEED with t=0.
REQ-017 FEED SHALL last exactly 2N-1 cycles, t = 0..2N-2, incrementing by 1 per cycle.
REQ-018 In FEED cycle t, matrix_W[i] SHALL equal A[i][k] with k=t-i+2 when 1<=k<=N, else 0.
REQ-019 In FEED cycle t, matrix_N[j] SHALL equal B[k][j] with k=t-j+2 when 1<=k<=N, else 0.
REQ-020 FLUSH SHALL last DRAIN cycles with matrix_W/matrix_N all zero; DRAIN=0 skips FLUSH.
REQ-021 DONE SHALL last 1 cycle with done=1 and return to IDLE.
REQ-022 busy SHALL be 1 in CLEAR, FEED, FLUSH and DONE, and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 start asserted in the DONE cycle SHALL be ignored; the earliest new acceptance is the following IDLE cycle.
REQ-025 Job length from acceptance edge to done pulse SHALL be 1+(2N-1)+DRAIN+1 cycles (N=4, DRAIN=4: 13).
REQ-026 Operands SHALL pass unmodified; no arithmetic or width change SHALL occur in this block.

Reset
REQ-027 rst_n=1 SHALL force IDLE, t=0, and busy=done=sa_clr=0, with matrix_W and matrix_N all zero on the next edge.
REQ-028 rst_n=1 during any non-IDLE state SHALL abort the job with no done pulse; captured matrices need not be cleared.
REQ-029 start coincident with rst_n=1 SHALL be ignored.

Verification
REQ-030 N=4, A[i][k]=4(i-1)+k, B=all 1s, start pulse -> sa_clr cycle, then FEED t=0 W=(1,0,0,0), N=(1,0,0,0); t=3 W=(4,7,10,13), N=(1,1,1,1); t=6 W=(0,0,0,16).
REQ-031 Same job with DRAIN=4 -> busy high for 13 cycles, done high in cycle 13 only, and 4 all-zero FLUSH cycles before it.
REQ-032 start held high for 20 cycles -> exactly one job, done at cycle 13, second acceptance at cycle 14.
REQ-033 mat_a changed to all 15s one cycle after acceptance -> FEED outputs still match the captured A.
REQ-034 rst_n=1 at FEED t=2 -> next cycle IDLE, all outputs 0, no done pulse; a new start then runs a full 13-cycle job.
REQ-035 End-to-end with the array, random 1..15 operands -> array output equals the reference product A*B at the done pulse.
